// File: rtl/shift_sequencer_64.sv
`default_nettype none
// ============================================================================
// Module   : shift_sequencer_64
// Brief    : Multi-cycle variable left shifter built from iterated shift-by-8
//            and shift-by-1 steps. Optional macro SHIFT_SEQ_FAST_BIT_EN makes
//            the residual 0..7 bit shift a single-cycle step.
// Revision : 1.0 - initial release
// ============================================================================
module shift_sequencer_64 #(
    parameter int WIDTH = 64,
    parameter int AMT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [AMT_W-1:0] amount,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BYTE = 2'd1,
        BIT  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [AMT_W-4:0] BYTE_ONE = {{(AMT_W-4){1'b0}}, 1'b1};

    state_t           state, state_next;
    logic [WIDTH-1:0] acc, acc_next;
    logic [AMT_W-4:0] byte_cnt, byte_cnt_next;
    logic [2:0]       bit_cnt, bit_cnt_next;

    always_comb begin
        state_next    = state;
        acc_next      = acc;
        byte_cnt_next = byte_cnt;
        bit_cnt_next  = bit_cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    acc_next      = a;
                    byte_cnt_next = amount[AMT_W-1:3];
                    bit_cnt_next  = amount[2:0];
                    if (amount[AMT_W-1:3] != '0)
                        state_next = BYTE;
                    else if (amount[2:0] != 3'd0)
                        state_next = BIT;
                    else
                        state_next = DONE;
                end
            end
            BYTE: begin
                acc_next      = acc << 8;
                byte_cnt_next = byte_cnt - BYTE_ONE;
                if (byte_cnt == BYTE_ONE)
                    state_next = (bit_cnt != 3'd0) ? BIT : DONE;
            end
            BIT: begin
`ifdef SHIFT_SEQ_FAST_BIT_EN
                acc_next     = acc << bit_cnt;
                bit_cnt_next = 3'd0;
                state_next   = DONE;
`else
                acc_next     = acc << 1;
                bit_cnt_next = bit_cnt - 3'd1;
                if (bit_cnt == 3'd1)
                    state_next = DONE;
`endif
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Result captures the final accumulator value on the edge that enters DONE,
    // so it is valid alongside the done pulse and stable otherwise.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            acc      <= '0;
            byte_cnt <= '0;
            bit_cnt  <= 3'd0;
            result   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_next;
            acc      <= acc_next;
            byte_cnt <= byte_cnt_next;
            bit_cnt  <= bit_cnt_next;
            busy     <= (state_next != IDLE);
            done     <= (state_next == DONE);
            if ((state_next == DONE) && (state != DONE))
                result <= acc_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_shift_sequencer_64.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_sequencer_64
// Brief    : Directed table-driven bench for shift_sequencer_64.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_sequencer_64;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [63:0] a;
    logic [5:0]  amount;
    logic        busy;
    logic        done;
    logic [63:0] result;

    int n_checks = 0;
    int n_fail   = 0;

    shift_sequencer_64 #(.WIDTH(64), .AMT_W(6)) dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .a      (a),
        .amount (amount),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [63:0] a;
        logic [5:0]  amt;
        logic [63:0] exp;
        int          lat_slow;
        int          lat_fast;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Pulses start for one edge and watches until the FSM returns to IDLE.
    task automatic run_op(input logic [63:0] op_a, input logic [5:0] op_amt,
                          output logic [63:0] res, output int lat,
                          output int busy_cyc, output int done_cyc);
        @(negedge clock);
        a = op_a; amount = op_amt; start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        res = '0; lat = 0; busy_cyc = 0; done_cyc = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clock);
            if (busy) busy_cyc++;
            if (done) begin
                done_cyc++;
                if (lat == 0) begin
                    lat = c;
                    res = result;
                end
            end
            if (!busy && lat != 0) break;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] res;
        int lat, bcyc, dcyc, exp_lat, npulse;
        bit seen;

        vecs[0] = '{64'h0123_4567_89AB_CDEF, 6'd8,  64'h2345_6789_ABCD_EF00, 2,  2};
        vecs[1] = '{64'hDEAD_BEEF_0000_0001, 6'd0,  64'hDEAD_BEEF_0000_0001, 1,  1};
        vecs[2] = '{64'h0000_0000_0000_00FF, 6'd13, 64'h0000_0000_001F_E000, 7,  3};
        vecs[3] = '{64'h0000_0000_0000_0001, 6'd63, 64'h8000_0000_0000_0000, 15, 9};
        vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 6'd63, 64'h8000_0000_0000_0000, 15, 9};
        vecs[5] = '{64'h0000_0000_0000_0001, 6'd1,  64'h0000_0000_0000_0002, 2,  2};
        vecs[6] = '{64'h8000_0000_0000_0001, 6'd7,  64'h0000_0000_0000_0080, 8,  2};
        vecs[7] = '{64'h0123_4567_89AB_CDEF, 6'd56, 64'hEF00_0000_0000_0000, 8,  8};
        vecs[8] = '{64'h0000_0000_0000_00A5, 6'd36, 64'h0000_0A50_0000_0000, 9,  6};

        reset = 1'b1; start = 1'b0; a = '0; amount = '0;
        repeat (2) @(negedge clock);
        check("reset_busy",   {63'd0, busy}, 64'd0);
        check("reset_done",   {63'd0, done}, 64'd0);
        check("reset_result", result,        64'd0);
        reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
`ifdef SHIFT_SEQ_FAST_BIT_EN
            exp_lat = vecs[i].lat_fast;
`else
            exp_lat = vecs[i].lat_slow;
`endif
            run_op(vecs[i].a, vecs[i].amt, res, lat, bcyc, dcyc);
            check($sformatf("vec%0d_result", i),  res,          vecs[i].exp);
            check($sformatf("vec%0d_latency", i), 64'(lat),     64'(exp_lat));
            check($sformatf("vec%0d_busy", i),    64'(bcyc),    64'(exp_lat));
            check($sformatf("vec%0d_pulses", i),  64'(dcyc),    64'd1);
            check($sformatf("vec%0d_held", i),    result,       vecs[i].exp);
        end

        // start pulsed while busy must be ignored
        @(negedge clock);
        a = 64'h1; amount = 6'd16; start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        @(negedge clock);
        a = 64'h2; amount = 6'd1; start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        npulse = 0; res = '0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clock);
            if (done) begin
                npulse++;
                res = result;
            end
        end
        check("busy_start_result", res,          64'h0000_0000_0001_0000);
        check("busy_start_pulses", 64'(npulse),  64'd1);

        // reset mid-operation clears outputs asynchronously
        @(negedge clock);
        a = 64'h3; amount = 6'd40; start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (3) @(negedge clock);
        check("pre_reset_busy", {63'd0, busy}, 64'd1);
        #2 reset = 1'b1;
        #1;
        check("async_reset_busy",   {63'd0, busy}, 64'd0);
        check("async_reset_done",   {63'd0, done}, 64'd0);
        check("async_reset_result", result,        64'd0);
        @(negedge clock);
        reset = 1'b0;
        run_op(64'h1, 6'd4, res, lat, bcyc, dcyc);
        check("post_reset_result",  res,      64'h10);
`ifdef SHIFT_SEQ_FAST_BIT_EN
        check("post_reset_latency", 64'(lat), 64'd2);
`else
        check("post_reset_latency", 64'(lat), 64'd5);
`endif

        // start held high: back-to-back ops, one IDLE gap, operand changes ignored in flight
        @(negedge clock);
        a = 64'h3; amount = 6'd2; start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        a = 64'h5;
        seen = 1'b0; res = '0;
        for (int c = 0; c < 20 && !seen; c++) begin
            if (done) begin
                seen = 1'b1;
                res = result;
            end else begin
                @(negedge clock);
            end
        end
        check("held_first_result", res, 64'hC);
        @(negedge clock);
        check("held_idle_gap", {63'd0, busy}, 64'd0);
        @(negedge clock);
        check("held_restart_busy", {63'd0, busy}, 64'd1);
        seen = 1'b0; res = '0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clock);
            if (done) begin
                seen = 1'b1;
                res = result;
            end
        end
        start = 1'b0;
        check("held_second_result", res, 64'h14);

        repeat (4) @(negedge clock);
        check("final_idle", {63'd0, busy}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/shift_sequencer_64.md
Name: shift_sequencer_64

Overview:
- Multi-cycle controller that applies a variable left shift (0..63) to a 64-bit operand.
- Reuses a fixed shift-by-8 stage and a shift-by-1 stage, applying them iteratively under FSM control.
- Sits between the ALU/multiplier control path and the fixed-shift datapath.
- Provides a start/busy/done handshake and a registered result.

Parameters:
- WIDTH, 64, operand/result width; must be a multiple of 8.
- AMT_W, 6, shift-amount width; equals log2(WIDTH).

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand; captured on the accepted start edge.
- amount  input  AMT_W  shift distance; captured on the accepted start edge.
- busy  output  1  high whenever the FSM is not in IDLE.
- done  output  1  one-cycle completion pulse.
- result  output  WIDTH  final shifted value; held until the next completion.

Behaviour:
- Reset (async, active-high), applied immediately regardless of clock:
  - state=IDLE, acc=0, byte_cnt=0, bit_cnt=0, result=0, done=0, busy=0.
- Internal registers:
  - acc[WIDTH-1:0]
  - byte_cnt = amount[AMT_W-1:3]
  - bit_cnt = amount[2:0]
- States: IDLE, BYTE, BIT, DONE.
- IDLE:
  - start=1 at an edge: acc<=a, byte_cnt<=amount[AMT_W-1:3], bit_cnt<=amount[2:0].
  - Next state: BYTE if the upper field is nonzero; else BIT if the lower field is nonzero; else DONE.
  - start=0: stay in IDLE.
- BYTE, each cycle: acc<=acc<<8 (zero fill), byte_cnt<=byte_cnt-1.
  - Leave BYTE when byte_cnt==1 before the decrement: go to BIT if bit_cnt!=0, else DONE.
- BIT, each cycle: acc<=acc<<1 (zero fill), bit_cnt<=bit_cnt-1.
  - Leave to DONE when bit_cnt==1 before the decrement.
- DONE, for one cycle:
  - done=1 and result=acc, both visible during this cycle (result register loaded on the edge entering DONE).
  - Next state: IDLE.
- Latency, counted from the start-sampling edge to the cycle done is high: floor(amount/8) + (amount mod 8) + 1 cycles.
  - amount=0 gives 1 cycle; amount=63 gives 15 cycles.
- busy and done are registered outputs decoded from state.
  - busy=1 in BYTE, BIT and DONE.
  - done=1 only in DONE.
- start while busy=1 (including the DONE cycle) is ignored. Operands are not re-sampled. No queueing.
- a/amount changes after acceptance have no effect on the operation in flight.
- Bits shifted past the MSB are discarded. No carry or overflow flag.
- result changes only on the edge entering DONE, or on reset. It is stable at all other times.
- Reset asserted mid-operation aborts immediately:
  - All state is cleared.
  - No done pulse.
  - result reads 0.
- start held high continuously: a new operation is accepted on the first IDLE edge after DONE, giving back-to-back operations with a one-cycle IDLE gap.

Optional Feature:
- Macro: SHIFT_SEQ_FAST_BIT_EN.
- Defined:
  - The BIT state performs acc<=acc<<bit_cnt in a single cycle, then goes to DONE.
  - Latency becomes floor(amount/8) + (amount mod 8 != 0 ? 1 : 0) + 1; amount=63 gives 9 cycles.
  - Results are identical to the undefined case.
- Undefined: one bit per cycle, as specified in Behaviour.

Test Plan:
- a=64'h0123_4567_89AB_CDEF, amount=8, start pulse -> done high 2 cycles after the start edge; result=64'h2345_6789_ABCD_EF00; busy high for 2 cycles.
- a=64'hDEAD_BEEF_0000_0001, amount=0 -> done 1 cycle after start; result equals a unchanged.
- a=64'h0000_0000_0000_00FF, amount=13 -> done after 7 cycles; result=64'h0000_0000_001F_E000. With SHIFT_SEQ_FAST_BIT_EN defined, done after 3 cycles with the same result.
- a=64'h1, amount=63 -> done after 15 cycles (9 with the macro); result=64'h8000_0000_0000_0000. Also a=64'hFFFF_FFFF_FFFF_FFFF, amount=63 -> same result; overflow bits discarded.
- Start amount=16, a=1. Pulse start with a=2, amount=1 in cycle 1 while busy -> ignored; result=64'h0000_0000_0001_0000; exactly one done pulse.
- Start amount=40, then assert reset 3 cycles later -> busy=0, done=0 and result=0 immediately without a clock edge. After release, a fresh start with a=1, amount=4 -> result=64'h10.
